seq_pattern_fsm: RTL and testbench

Parametrised serial pattern-detector FSM, the successor to the team's fixed single-input Moore FSMs. It samples a 1-bit serial stream, tracks the longest matched prefix of a compile-time pattern, and raises a registered one-cycle match pulse. It adds a valid qualifier, overlapping or non-overlapping mode, and a saturating match counter. It sits on serial-decode paths that previously used hand-coded 1-bit state machines.

---
 rtl/seq_pattern_pkg.sv | 67 ++++++
 rtl/seq_pattern_fsm_sat_counter.sv | 36 +++
 rtl/seq_pattern_fsm.sv | 104 ++++++++++
 tb/tb_seq_pattern_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: shared helpers for the serial pattern detector.
//   state_w      - width needed to hold a matched-prefix length 0..pat_w
//   pat_bit      - i-th received bit of a pattern (index 0 = MSB, received first)
//   kmp_next     - longest suffix of (first s pattern bits, then b) that is a prefix
//                  of the pattern; a result equal to pat_w means a full match
//   border_len   - longest proper prefix of the pattern that is also a suffix
// Patterns are passed zero-extended to MAX_PAT_W bits together with their true
// width. These functions are evaluated at elaboration time to build constant
// transition tables, so the loops cost no logic.
package seq_pattern_pkg;

   localparam int MAX_PAT_W = 16;

   function automatic int state_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int w,
                                    input int i);
      logic [MAX_PAT_W-1:0] t;
      t = pat >> (w - 1 - i);
      return t[0];
   endfunction

   function automatic int kmp_next(input int s, input logic b,
                                   input logic [MAX_PAT_W-1:0] pat, input int w);
      int   best;
      int   j;
      logic ok;
      logic cand;
      best = 0;
      for (int k = 1; k <= MAX_PAT_W; k++) begin
         if (k <= s + 1 && k <= w) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < k) begin
                  // candidate string position aligned with pattern bit i
                  j = s + 1 - k + i;
                  cand = (j == s) ? b : pat_bit(pat, w, j);
                  if (cand != pat_bit(pat, w, i)) ok = 1'b0;
               end
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   function automatic int border_len(input logic [MAX_PAT_W-1:0] pat, input int w);
      int   best;
      logic ok;
      best = 0;
      for (int k = 1; k < MAX_PAT_W; k++) begin
         if (k < w) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < k) begin
                  if (pat_bit(pat, w, i) != pat_bit(pat, w, w - k + i)) ok = 1'b0;
               end
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_pattern_fsm_sat_counter.sv
// sat_counter: saturating up-counter, holds at all-ones instead of wrapping.
// Ports:
//   clk     - clock, rising edge
//   areset  - asynchronous active-high reset, clears the count
//   inc     - count up by one on this edge (ignored once saturated)
//   cnt     - current count
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_fsm.sv
// seq_pattern_fsm: serial pattern detector with KMP fallback.
// Tracks the longest matched prefix of PATTERN (MSB received first) over valid
// input bits and emits a registered one-cycle pulse when the pattern completes.
// Ports:
//   clk        - clock, rising edge
//   areset     - asynchronous active-high reset (state, out, match_cnt to 0)
//   in         - serial data bit
//   in_valid   - in is sampled only when high; otherwise state holds
//   overlap    - 1: after a match resume at the pattern's border, 0: restart at 0
//   out        - registered match pulse
//   match_cnt  - saturating match count
//   state_dbg  - current matched-prefix length
// Build option: define SEQ_PATTERN_CNT_EN to implement match_cnt; when undefined
// no counter is built and match_cnt reads 0.
module seq_pattern_fsm
   import seq_pattern_pkg::*;
#(
   parameter int             PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int             CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       in,
   input  logic                       in_valid,
   input  logic                       overlap,
   output logic                       out,
   output logic [CNT_W-1:0]           match_cnt,
   output logic [$clog2(PAT_W+1)-1:0] state_dbg
);

   localparam int SW = state_w(PAT_W);
   localparam int NS = 2 ** SW;
   localparam logic [MAX_PAT_W-1:0] PAT16 = MAX_PAT_W'(PATTERN);

   // Resume point after an overlapping match.
   localparam logic [SW-1:0] ST_BORDER = SW'(border_len(PAT16, PAT_W));
   localparam logic [SW-1:0] ST_IDLE   = '0;

   // Constant next-state and match tables indexed by (state, bit). Sized to the
   // full state encoding so the lookup needs no range guard; unreachable rows
   // fall back to idle.
   logic [SW-1:0] nxt_tab [NS][2];
   logic          hit_tab [NS][2];

   for (genvar s = 0; s < NS; s++) begin : g_s
      for (genvar b = 0; b < 2; b++) begin : g_b
         if (s < PAT_W) begin : g_live
            localparam int K = kmp_next(s, 1'(b), PAT16, PAT_W);
            assign nxt_tab[s][b] = SW'(K);
            assign hit_tab[s][b] = (K == PAT_W);
         end else begin : g_dead
            assign nxt_tab[s][b] = ST_IDLE;
            assign hit_tab[s][b] = 1'b0;
         end
      end
   end

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic          out_q;
   logic          out_d;

   always_comb begin
      state_d = state_q;
      out_d   = 1'b0;
      if (in_valid) begin
         if (hit_tab[state_q][in]) begin
            out_d   = 1'b1;
            state_d = overlap ? ST_BORDER : ST_IDLE;
         end else begin
            state_d = nxt_tab[state_q][in];
         end
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign out       = out_q;
   assign state_dbg = state_q;

`ifdef SEQ_PATTERN_CNT_EN
   // Counts on the same edge that raises out, so both update together.
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .areset (areset),
      .inc    (out_d),
      .cnt    (match_cnt)
   );
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_fsm.sv
module tb_seq_pattern_fsm;

   logic       clk = 1'b0;
   logic       areset;
   logic       in;
   logic       in_valid;
   logic       overlap;
   logic       out;
   logic [7:0] match_cnt;
   logic [2:0] state_dbg;
   logic       out2;
   logic [1:0] cnt2;
   logic [2:0] sd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_pattern_fsm #(
      .PAT_W   (4),
      .PATTERN (4'b1011),
      .CNT_W   (8)
   ) dut (
      .clk       (clk),
      .areset    (areset),
      .in        (in),
      .in_valid  (in_valid),
      .overlap   (overlap),
      .out       (out),
      .match_cnt (match_cnt),
      .state_dbg (state_dbg)
   );

   seq_pattern_fsm #(
      .PAT_W   (4),
      .PATTERN (4'b1011),
      .CNT_W   (2)
   ) dut2 (
      .clk       (clk),
      .areset    (areset),
      .in        (in),
      .in_valid  (in_valid),
      .overlap   (overlap),
      .out       (out2),
      .match_cnt (cnt2),
      .state_dbg (sd2)
   );

   // Expected counter value depends on whether the counter is built.
   function automatic int ecnt(input int n);
`ifdef SEQ_PATTERN_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Apply one bit and return 1 time unit after the sampling edge.
   task automatic send(input logic v, input logic b);
      in_valid = v;
      in       = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check3(input string tag, input logic eo, input int es, input int ec);
      chk({tag, "_out"}, 32'(out), 32'(eo));
      chk({tag, "_sd"}, 32'(state_dbg), es);
      chk({tag, "_cnt"}, 32'(match_cnt), ecnt(ec));
   endtask

   task automatic do_reset();
      areset   = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in = ~in;
         @(posedge clk);
         #1;
         check3("reset", 1'b0, 0, 0);
      end
      areset   = 1'b0;
      in_valid = 1'b0;
   endtask

   logic [6:0] st3     = 7'b1011011;
   int         ov_out[7] = '{0, 0, 0, 1, 0, 0, 1};
   int         ov_sd[7]  = '{1, 2, 3, 1, 2, 3, 1};
   int         ov_cnt[7] = '{0, 0, 0, 1, 1, 1, 2};
   int         no_out[7] = '{0, 0, 0, 1, 0, 0, 0};
   int         no_sd[7]  = '{1, 2, 3, 0, 0, 1, 1};
   int         no_cnt[7] = '{0, 0, 0, 1, 1, 1, 1};
   logic [5:0] st4     = 6'b101011;
   int         fb_out[6] = '{0, 0, 0, 0, 0, 1};
   int         fb_sd[6]  = '{1, 2, 3, 2, 3, 1};
   logic [3:0] pat     = 4'b1011;

   initial begin
      areset   = 1'b1;
      in       = 1'b0;
      in_valid = 1'b0;
      overlap  = 1'b1;

      // Reset holds everything at zero while inputs toggle.
      do_reset();

      // Basic match.
      send(1'b1, 1'b1); check3("basic1", 1'b0, 1, 0);
      send(1'b1, 1'b0); check3("basic2", 1'b0, 2, 0);
      send(1'b1, 1'b1); check3("basic3", 1'b0, 3, 0);
      send(1'b1, 1'b1); check3("basic4", 1'b1, 1, 1);
      send(1'b0, 1'b1); check3("basic_idle", 1'b0, 1, 1);

      // Overlapping matches.
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(1'b1, st3[6-i]);
         check3("ovl", 1'(ov_out[i]), ov_sd[i], ov_cnt[i]);
      end

      // Non-overlapping: restart after the match.
      do_reset();
      overlap = 1'b0;
      for (int i = 0; i < 7; i++) begin
         send(1'b1, st3[6-i]);
         check3("novl", 1'(no_out[i]), no_sd[i], no_cnt[i]);
      end

      // KMP fallback without gaps.
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, st4[5-i]);
         check3("fb", 1'(fb_out[i]), fb_sd[i], fb_out[i]);
      end

      // Same stream with three invalid cycles of random data after each bit.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send(1'b1, st4[5-i]);
         check3("fbgap", 1'(fb_out[i]), fb_sd[i], fb_out[i]);
         for (int g = 0; g < 3; g++) begin
            send(1'b0, 1'($urandom_range(1, 0)));
            check3("gap", 1'b0, fb_sd[i], fb_out[i]);
         end
      end

      // Saturation on the 2-bit counter instance, five non-overlapping matches.
      do_reset();
      overlap = 1'b0;
      for (int m = 1; m <= 5; m++) begin
         for (int i = 0; i < 4; i++) send(1'b1, pat[3-i]);
         chk("sat_out2", 32'(out2), 32'd1);
         chk("sat_cnt2", 32'(cnt2), ecnt((m > 3) ? 3 : m));
         chk("sat_cnt8", 32'(match_cnt), ecnt(m));
         chk("sat_sd2", 32'(sd2), 0);
      end

      // Reset mid-pattern discards partial progress.
      do_reset();
      overlap = 1'b1;
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b1); check3("mid_pre", 1'b0, 3, 0);
      areset = 1'b1;
      #1;
      chk("mid_async_sd", 32'(state_dbg), 0);
      #2;
      areset = 1'b0;
      send(1'b1, 1'b1); check3("mid_post", 1'b0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
